// File: rtl/dm_arbiter_if.sv
// dm_arbiter_if: bundle of the two requester ports (C = CPU MEM stage,
// D = debug/DMA bridge) and the data-memory side of dm_arbiter.
//
// Handshake: a requester raises req together with its payload
// (we, op, signed, addr, wdata) and holds all of them stable until it sees
// gnt high in the same cycle. gnt is the completion of a store. A load
// returns exactly one rvalid pulse, with rdata, in the cycle after its gnt.
// err pulses in that same following cycle if the granted access was illegal.
// There is no back-pressure on responses.
//
// slave  : the arbiter's view (requests and m_rdata in; grants, responses
//          and memory controls out).
// master : the environment's view (requesters plus the RAM).
interface dm_arbiter_if #(
    parameter int AW = 10
);
    // CPU port
    logic          c_req;
    logic          c_we;
    logic [1:0]    c_op;
    logic          c_signed;
    logic [31:0]   c_addr;
    logic [31:0]   c_wdata;
    logic          c_gnt;
    logic          c_rvalid;
    logic [31:0]   c_rdata;
    logic          c_err;

    // Bridge port
    logic          d_req;
    logic          d_we;
    logic [1:0]    d_op;
    logic          d_signed;
    logic [31:0]   d_addr;
    logic [31:0]   d_wdata;
    logic          d_gnt;
    logic          d_rvalid;
    logic [31:0]   d_rdata;
    logic          d_err;

    // Memory side
    logic          m_en;
    logic [3:0]    m_we;
    logic [AW-1:0] m_addr;
    logic [31:0]   m_wdata;
    logic [31:0]   m_rdata;

    modport slave (
        input  c_req, c_we, c_op, c_signed, c_addr, c_wdata,
        output c_gnt, c_rvalid, c_rdata, c_err,
        input  d_req, d_we, d_op, d_signed, d_addr, d_wdata,
        output d_gnt, d_rvalid, d_rdata, d_err,
        output m_en, m_we, m_addr, m_wdata,
        input  m_rdata
    );

    modport master (
        output c_req, c_we, c_op, c_signed, c_addr, c_wdata,
        input  c_gnt, c_rvalid, c_rdata, c_err,
        output d_req, d_we, d_op, d_signed, d_addr, d_wdata,
        input  d_gnt, d_rvalid, d_rdata, d_err,
        input  m_en, m_we, m_addr, m_wdata,
        output m_rdata
    );
endinterface

// File: rtl/dm_arbiter.sv
// dm_arbiter: shares one synchronous-read 2^AW x 32 data RAM between the
// CPU MEM stage (port C) and the debug/DMA bridge (port D). At most one
// access is granted per cycle. The granted request is turned into a word
// address, byte strobes and lane-replicated write data. Load data comes back
// one cycle later and is formatted for the owning port.
//
// Build option: define DM_ARB_FIXED_PRIO_EN to make C always win a conflict.
// In that build the round-robin history register does not exist, so D can
// starve. By default, conflicts alternate.
module dm_arbiter #(
    parameter int AW = 10
) (
    input  logic         clk,
    input  logic         reset,
    dm_arbiter_if.slave  bus
);
    localparam logic [1:0] OP_WORD = 2'd0;
    localparam logic [1:0] OP_HALF = 2'd1;
    localparam logic [1:0] OP_BYTE = 2'd2;

    logic        gnt_c;
    logic        gnt_d;
    logic        any_gnt;
    logic        sel_we;
    logic [1:0]  sel_op;
    logic        sel_signed;
    logic [31:0] sel_addr;
    logic [31:0] sel_wdata;
    logic        illegal;
    logic [3:0]  strobe;
    logic [31:0] rep_wdata;

    // Load-response context, captured on every granted load
    logic        rsp_valid;
    logic        rsp_owner_d;
    logic [1:0]  rsp_op;
    logic [1:0]  rsp_lane;
    logic        rsp_signed;
    logic        rsp_illegal;
    logic        err_c;
    logic        err_d;
    logic [31:0] fmt_rdata;
    logic [15:0] lane_half;
    logic [7:0]  lane_byte;

    // Word-address bits above the RAM are intentionally ignored
    logic        unused_addr_bits;
    assign unused_addr_bits = ^sel_addr[31:AW+2];

`ifdef DM_ARB_FIXED_PRIO_EN
    // C always wins a conflict; reset blocks every grant
    always_comb begin
        gnt_c = !reset && bus.c_req;
        gnt_d = !reset && bus.d_req && !bus.c_req;
    end
`else
    // 1 = D won the most recent grant, so C is next in line on a conflict
    logic last_d;

    // Round-robin: a lone requester wins; on conflict the previous loser wins
    always_comb begin
        gnt_c = !reset && bus.c_req && (!bus.d_req || last_d);
        gnt_d = !reset && bus.d_req && (!bus.c_req || !last_d);
    end

    // Remember the winner of every grant; reset makes C the first winner
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            last_d <= 1'b1;
        end else if (gnt_d) begin
            last_d <= 1'b1;
        end else if (gnt_c) begin
            last_d <= 1'b0;
        end
    end
`endif

    assign any_gnt   = gnt_c || gnt_d;
    assign bus.c_gnt = gnt_c;
    assign bus.d_gnt = gnt_d;

    // Forward the payload of whichever port holds the grant
    always_comb begin
        sel_we     = gnt_d ? bus.d_we     : bus.c_we;
        sel_op     = gnt_d ? bus.d_op     : bus.c_op;
        sel_signed = gnt_d ? bus.d_signed : bus.c_signed;
        sel_addr   = gnt_d ? bus.d_addr   : bus.c_addr;
        sel_wdata  = gnt_d ? bus.d_wdata  : bus.c_wdata;
    end

    // Decode width and alignment into legality, strobes and replicated data
    always_comb begin
        illegal   = 1'b0;
        strobe    = 4'b0000;
        rep_wdata = 32'h0;
        case (sel_op)
            OP_WORD: begin
                illegal   = (sel_addr[1:0] != 2'b00);
                strobe    = 4'b1111;
                rep_wdata = sel_wdata;
            end
            OP_HALF: begin
                illegal   = sel_addr[0];
                strobe    = sel_addr[1] ? 4'b1100 : 4'b0011;
                rep_wdata = {2{sel_wdata[15:0]}};
            end
            OP_BYTE: begin
                strobe    = 4'b0001 << sel_addr[1:0];
                rep_wdata = {4{sel_wdata[7:0]}};
            end
            default: begin
                illegal   = 1'b1;
            end
        endcase
    end

    // Illegal accesses are granted but never reach the RAM
    always_comb begin
        bus.m_en    = any_gnt && !illegal;
        bus.m_we    = (any_gnt && !illegal && sel_we) ? strobe : 4'b0000;
        bus.m_addr  = sel_addr[AW+1:2];
        bus.m_wdata = rep_wdata;
    end

    // Capture the response context of each granted load and the err pulses;
    // reset discards any response still in flight
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rsp_valid   <= 1'b0;
            rsp_owner_d <= 1'b0;
            rsp_op      <= 2'd0;
            rsp_lane    <= 2'd0;
            rsp_signed  <= 1'b0;
            rsp_illegal <= 1'b0;
            err_c       <= 1'b0;
            err_d       <= 1'b0;
        end else begin
            rsp_valid <= any_gnt && !sel_we;
            err_c     <= gnt_c && illegal;
            err_d     <= gnt_d && illegal;
            if (any_gnt && !sel_we) begin
                rsp_owner_d <= gnt_d;
                rsp_op      <= sel_op;
                rsp_lane    <= sel_addr[1:0];
                rsp_signed  <= sel_signed;
                rsp_illegal <= illegal;
            end
        end
    end

    // Extract the addressed lane and extend it; illegal loads return zero
    always_comb begin
        lane_half = rsp_lane[1] ? bus.m_rdata[31:16] : bus.m_rdata[15:0];
        lane_byte = bus.m_rdata[{rsp_lane, 3'b000} +: 8];
        fmt_rdata = 32'h0;
        if (!rsp_illegal) begin
            case (rsp_op)
                OP_WORD: fmt_rdata = bus.m_rdata;
                OP_HALF: fmt_rdata = {{16{rsp_signed & lane_half[15]}}, lane_half};
                OP_BYTE: fmt_rdata = {{24{rsp_signed & lane_byte[7]}}, lane_byte};
                default: fmt_rdata = 32'h0;
            endcase
        end
    end

    // Route the response to its owner only; the other port sees zero
    always_comb begin
        bus.c_rvalid = rsp_valid && !rsp_owner_d;
        bus.d_rvalid = rsp_valid && rsp_owner_d;
        bus.c_rdata  = bus.c_rvalid ? fmt_rdata : 32'h0;
        bus.d_rdata  = bus.d_rvalid ? fmt_rdata : 32'h0;
        bus.c_err    = err_c;
        bus.d_err    = err_d;
    end
endmodule

// File: tb/tb_dm_arbiter.sv
// tb_dm_arbiter: drives dm_arbiter with directed and randomized traffic and
// compares it, cycle by cycle, against a byte-addressed memory model and the
// grant rules. A small synchronous RAM behind the memory port stands in for
// the data RAM.
module tb_dm_arbiter;
    localparam int AW = 10;

    logic clk;
    logic reset;

    dm_arbiter_if #(.AW(AW)) bus ();

    dm_arbiter #(.AW(AW)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- data RAM (write-before-read) ----------------
    logic [31:0] ram [0:(1<<AW)-1] = '{default: 32'h0};
    always @(posedge clk) begin
        if (bus.m_en) begin
            for (int i = 0; i < 4; i++)
                if (bus.m_we[i]) ram[bus.m_addr][8*i +: 8] <= bus.m_wdata[8*i +: 8];
            if (bus.m_we == 4'b0000) bus.m_rdata <= ram[bus.m_addr];
        end
    end

    // ---------------- scoreboard / reference model ----------------
    int n_checks = 0;
    int n_pass   = 0;
    logic [31:0] exp_q[$];
    logic [7:0]  mem_b [0:4095] = '{default: 8'h00};
    int   m_last = 1;          // 0 = C, 1 = D won the last grant
    int   m_win  = -1;         // winner in the most recent cycle
    logic exp_rv_c, exp_rv_d, exp_err_c, exp_err_d;
    logic obs_gc, obs_gd, obs_m_en, obs_rv_c, obs_err_c;
    logic [3:0]  obs_m_we;
    logic [31:0] obs_m_wdata, obs_rd_c, obs_rd_d;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, got, exp);
    endtask

    // ---------------- driver tasks ----------------
    task automatic drive_c(input logic we, input logic [1:0] op, input logic sg,
                           input logic [31:0] addr, input logic [31:0] wd);
        bus.c_req = 1'b1; bus.c_we = we; bus.c_op = op; bus.c_signed = sg;
        bus.c_addr = addr; bus.c_wdata = wd;
    endtask

    task automatic drive_d(input logic we, input logic [1:0] op, input logic sg,
                           input logic [31:0] addr, input logic [31:0] wd);
        bus.d_req = 1'b1; bus.d_we = we; bus.d_op = op; bus.d_signed = sg;
        bus.d_addr = addr; bus.d_wdata = wd;
    endtask

    task automatic idle();
        bus.c_req = 1'b0;
        bus.d_req = 1'b0;
    endtask

    task automatic model_reset();
        exp_q.delete();
        exp_rv_c = 1'b0; exp_rv_d = 1'b0; exp_err_c = 1'b0; exp_err_d = 1'b0;
        m_last = 1;
        m_win  = -1;
    endtask

    // One clock cycle: inputs are already driven. At the falling edge, check
    // the response owed from the previous cycle. Then check this cycle's
    // grant and memory controls against the model, and advance the model.
    task automatic cycle();
        int nb, base;
        logic        we, sg, ill;
        logic [1:0]  op;
        logic [31:0] a, wd, ewd, v, e;
        logic [3:0]  stb;
        @(negedge clk);
        obs_rv_c = bus.c_rvalid; obs_err_c = bus.c_err;
        obs_rd_c = bus.c_rdata;  obs_rd_d  = bus.d_rdata;
        check("c_rvalid", 32'(bus.c_rvalid), 32'(exp_rv_c));
        check("d_rvalid", 32'(bus.d_rvalid), 32'(exp_rv_d));
        check("c_err", 32'(bus.c_err), 32'(exp_err_c));
        check("d_err", 32'(bus.d_err), 32'(exp_err_d));
        if (exp_rv_c || exp_rv_d) begin
            e = (exp_q.size() != 0) ? exp_q.pop_front() : 32'hDEAD_BEEF;
            if (exp_rv_c) check("c_rdata", bus.c_rdata, e);
            else          check("d_rdata", bus.d_rdata, e);
        end
        if (!exp_rv_c) check("c_rdata_idle", bus.c_rdata, 32'h0);
        if (!exp_rv_d) check("d_rdata_idle", bus.d_rdata, 32'h0);
        exp_rv_c = 1'b0; exp_rv_d = 1'b0; exp_err_c = 1'b0; exp_err_d = 1'b0;

        m_win = -1;
        if (bus.c_req && bus.d_req) begin
`ifdef DM_ARB_FIXED_PRIO_EN
            m_win = 0;
`else
            m_win = (m_last == 0) ? 1 : 0;
`endif
        end else if (bus.c_req) m_win = 0;
        else if (bus.d_req)     m_win = 1;

        obs_gc = bus.c_gnt; obs_gd = bus.d_gnt; obs_m_en = bus.m_en;
        obs_m_we = bus.m_we; obs_m_wdata = bus.m_wdata;
        check("c_gnt", 32'(bus.c_gnt), (m_win == 0) ? 32'd1 : 32'd0);
        check("d_gnt", 32'(bus.d_gnt), (m_win == 1) ? 32'd1 : 32'd0);

        if (m_win >= 0) begin
            if (m_win == 0) begin
                we = bus.c_we; op = bus.c_op; sg = bus.c_signed; a = bus.c_addr; wd = bus.c_wdata;
            end else begin
                we = bus.d_we; op = bus.d_op; sg = bus.d_signed; a = bus.d_addr; wd = bus.d_wdata;
            end
            nb   = (op == 2'd0) ? 4 : (op == 2'd1) ? 2 : 1;
            ill  = (op == 2'd3) || ((int'(a[1:0]) % nb) != 0);
            base = int'(a[11:2]) * 4;
            stb  = 4'b0000;
            if (!ill) for (int k = 0; k < nb; k++) stb[int'(a[1:0]) + k] = 1'b1;
            for (int i = 0; i < 4; i++) ewd[8*i +: 8] = wd[8*(i % nb) +: 8];

            check("m_en", 32'(bus.m_en), ill ? 32'd0 : 32'd1);
            check("m_we", 32'(bus.m_we), we ? 32'(stb) : 32'd0);
            if (!ill) begin
                check("m_addr", 32'(bus.m_addr), 32'(a[11:2]));
                if (we) check("m_wdata", bus.m_wdata, ewd);
            end

            if (we && !ill)
                for (int i = 0; i < 4; i++)
                    if (stb[i]) mem_b[base + i] = ewd[8*i +: 8];
            if (!we) begin
                v = 32'h0;
                if (!ill) begin
                    for (int k = 0; k < nb; k++)
                        v = v | (32'(mem_b[base + int'(a[1:0]) + k]) << (8*k));
                    if (sg && nb < 4 && v[8*nb-1]) v = v | (32'hFFFF_FFFF << (8*nb));
                end
                exp_q.push_back(v);
                if (m_win == 0) exp_rv_c = 1'b1; else exp_rv_d = 1'b1;
            end
            if (ill) begin
                if (m_win == 0) exp_err_c = 1'b1; else exp_err_d = 1'b1;
            end
            m_last = m_win;
        end else begin
            check("m_en_idle", 32'(bus.m_en), 32'd0);
            check("m_we_idle", 32'(bus.m_we), 32'd0);
        end
        @(posedge clk);
        #1;
    endtask

    // Random payload for one port, mostly aligned and mostly legal
    task automatic rand_payload(output logic we, output logic [1:0] op, output logic sg,
                                output logic [31:0] addr, output logic [31:0] wd);
        we   = 1'($urandom_range(0, 1));
        sg   = 1'($urandom_range(0, 1));
        op   = ($urandom_range(0, 19) == 0) ? 2'd3 : 2'($urandom_range(0, 2));
        addr = 32'($urandom_range(0, 255));
        if ($urandom_range(0, 9) < 8) begin
            if (op == 2'd0) addr[1:0] = 2'b00;
            if (op == 2'd1) addr[0]   = 1'b0;
        end
        if ($urandom_range(0, 3) == 0) addr = addr | ($urandom() & 32'hFFFF_F000);
        wd = $urandom();
    endtask

    // ---------------- stimulus ----------------
    logic [3:0] lane_tab [4] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000};
    logic       rr_c_tab [5];

    initial begin
        logic        we, sg;
        logic [1:0]  op;
        logic [31:0] addr, wd;

`ifdef DM_ARB_FIXED_PRIO_EN
        rr_c_tab = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1};
`else
        rr_c_tab = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
`endif
        model_reset();
        reset = 1'b1;
        idle();
        drive_c(1'b0, 2'd0, 1'b0, 32'h10, 32'h0);
        drive_d(1'b0, 2'd0, 1'b0, 32'h20, 32'h0);
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_c_gnt", 32'(bus.c_gnt), 32'd0);
        check("rst_d_gnt", 32'(bus.d_gnt), 32'd0);
        check("rst_m_en", 32'(bus.m_en), 32'd0);
        check("rst_m_we", 32'(bus.m_we), 32'd0);
        check("rst_c_rvalid", 32'(bus.c_rvalid), 32'd0);
        check("rst_d_rvalid", 32'(bus.d_rvalid), 32'd0);
        check("rst_c_err", 32'(bus.c_err), 32'd0);
        check("rst_c_rdata", bus.c_rdata, 32'h0);
        @(posedge clk);
        #1 reset = 1'b0;

        // Round-robin conflict from reset: C, D, C, D
        for (int i = 0; i < 4; i++) begin
            cycle();
            check("rr_c_gnt", 32'(obs_gc), 32'(rr_c_tab[i]));
        end
        idle();
        cycle();

        // Half store, then signed and unsigned half loads
        drive_c(1'b1, 2'd1, 1'b0, 32'h6, 32'h0000_8001);
        cycle();
        check("half_st_we", 32'(obs_m_we), 32'h0000_000C);
        check("half_st_wdata", obs_m_wdata, 32'h8001_8001);
        drive_c(1'b0, 2'd1, 1'b1, 32'h6, 32'h0);
        cycle();
        drive_c(1'b0, 2'd1, 1'b0, 32'h6, 32'h0);
        cycle();
        check("half_ld_signed", obs_rd_c, 32'hFFFF_8001);
        idle();
        cycle();
        check("half_ld_unsigned", obs_rd_c, 32'h0000_8001);

        // Byte lanes through the bridge port
        for (int i = 0; i < 4; i++) begin
            drive_d(1'b1, 2'd2, 1'b0, 32'h40 + 32'(i), 32'h0000_00A5);
            cycle();
            check("byte_lane_we", 32'(obs_m_we), 32'(lane_tab[i]));
        end
        drive_d(1'b0, 2'd0, 1'b0, 32'h40, 32'h0);
        cycle();
        idle();
        cycle();
        check("byte_word_ld", obs_rd_d, 32'hA5A5_A5A5);

        // Misaligned word load
        drive_c(1'b0, 2'd0, 1'b0, 32'h13, 32'h0);
        cycle();
        check("mis_gnt", 32'(obs_gc), 32'd1);
        check("mis_m_en", 32'(obs_m_en), 32'd0);
        idle();
        cycle();
        check("mis_err", 32'(obs_err_c), 32'd1);
        check("mis_rvalid", 32'(obs_rv_c), 32'd1);
        check("mis_rdata", obs_rd_c, 32'h0);

        // Randomized traffic; a refused requester keeps its payload
        for (int n = 0; n < 400; n++) begin
            if (!(bus.c_req && m_win != 0)) begin
                if ($urandom_range(0, 9) < 6) begin
                    rand_payload(we, op, sg, addr, wd);
                    drive_c(we, op, sg, addr, wd);
                end else bus.c_req = 1'b0;
            end
            if (!(bus.d_req && m_win != 1)) begin
                if ($urandom_range(0, 9) < 6) begin
                    rand_payload(we, op, sg, addr, wd);
                    drive_d(we, op, sg, addr, wd);
                end else bus.d_req = 1'b0;
            end
            cycle();
        end
        idle();
        cycle();

        // Reset asserted between a C load grant and its response
        drive_c(1'b0, 2'd0, 1'b0, 32'h8, 32'h0);
        @(negedge clk);
        check("rma_gnt_before", 32'(bus.c_gnt), 32'd1);
        #2 reset = 1'b1;
        #1;
        check("rma_gnt_drop", 32'(bus.c_gnt), 32'd0);
        check("rma_m_en", 32'(bus.m_en), 32'd0);
        @(posedge clk);
        #1 idle();
        @(negedge clk);
        check("rma_no_rvalid", 32'(bus.c_rvalid), 32'd0);
        check("rma_rdata", bus.c_rdata, 32'h0);
        @(posedge clk);
        #1 reset = 1'b0;
        model_reset();

        // Continuous conflict after release: C first, then per build policy
        drive_c(1'b0, 2'd0, 1'b0, 32'h10, 32'h0);
        drive_d(1'b0, 2'd0, 1'b0, 32'h20, 32'h0);
        for (int i = 0; i < 5; i++) begin
            cycle();
            check("conf_c_gnt", 32'(obs_gc), 32'(rr_c_tab[i]));
            check("conf_d_gnt", 32'(obs_gd), 32'(!rr_c_tab[i]));
        end
        idle();
        cycle();
        check("exp_q_drained", 32'(exp_q.size()), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule

// File: doc/dm_arbiter.md
# dm_arbiter

Two-port arbiter and access sequencer for the single-port 1024×32 data memory. It shares the memory between the CPU MEM stage (port C) and the debug/DMA bridge (port D). Per cycle it grants at most one requester and turns the width/sign request into word address, byte strobes and replicated write data. It returns load data one cycle later, extracted and sign/zero-extended for the owning port. The block sits between the pipeline MEM stage and a synchronous-read data RAM.

## Interface
Parameters:
- AW, 10, word-address width; memory depth is 2^AW words.

Ports:
- clk  in  1  system clock; all state updates on rising edge.
- reset  in  1  asynchronous, active-high; clears all state immediately.
- c_req  in  1  CPU access request; held with its payload until c_gnt.
- c_we  in  1  1 = store, 0 = load.
- c_op  in  2  access width: 00 word, 01 half, 10 byte, 11 reserved.
- c_signed  in  1  load extension: 1 = sign, 0 = zero.
- c_addr  in  32  byte address; bits [AW+1:2] select the word.
- c_wdata  in  32  store data, right-aligned.
- c_gnt  out  1  access accepted this cycle (combinational).
- c_rvalid  out  1  load data valid on c_rdata.
- c_rdata  out  32  formatted load data.
- c_err  out  1  one-cycle pulse: the granted access was misaligned or reserved.
- d_req, d_we, d_op, d_signed, d_addr, d_wdata, d_gnt, d_rvalid, d_rdata, d_err: same widths and meanings for the bridge port.
- m_en  out  1  memory enable.
- m_we  out  4  byte write strobes; bit i covers bits [8i+7:8i].
- m_addr  out  AW  word address.
- m_wdata  out  32  lane-replicated store data.
- m_rdata  in  32  memory read word, valid the cycle after m_en with m_we = 0.

## Operation
- Grant:
  - Only one requester → it is granted.
  - Both requesting → round-robin: grant the port that was not the last winner.
  - Register `last` updates on every grant; reset value selects C as the first winner.
- Strobes for a legal granted access:
  - Word → 1111.
  - Half → addr[1] ? 1100 : 0011.
  - Byte → 0001 << addr[1:0].
  - Loads drive m_en = 1 and m_we = 0000.
- Write data:
  - Word → wdata.
  - Half → {2{wdata[15:0]}}.
  - Byte → {4{wdata[7:0]}}.
- Illegal access:
  - Conditions: word with addr[1:0] ≠ 0, half with addr[0] ≠ 0, or op = 11.
  - The access is still granted, so the requester never stalls.
  - m_en = 0 and m_we = 0000; memory is untouched.
  - The owner's err pulses next cycle.
  - If the illegal access is a load, rvalid also pulses next cycle with rdata = 0.
- Response register: on each granted load, capture {owner, op, addr[1:0], signed, illegal}.
- Load extraction:
  - Half → lane addr[1] taken from m_rdata, upper 16 bits = signed ? bit15 : 0.
  - Byte → lane addr[1:0], upper 24 bits = signed ? bit7 : 0.
  - Word → m_rdata unchanged.
- rdata is 0 on the non-owning port and whenever rvalid = 0.
- Stores produce no rvalid; gnt is the completion.

## Timing
- Cycle T: req high → gnt, m_en, m_we, m_addr, m_wdata all combinational in T. The memory samples at the rising edge ending T.
- Load latency: rvalid and rdata on the owning port in T+1. err also appears in T+1.
- Back-to-back: a new grant is allowed in T+1 while the response from T is returned. Full throughput is one access per cycle.
- Store in T followed by a load to the same word in T+1 returns the new data; the memory provides write-before-read.
- Simultaneous requests: the loser keeps req high and is granted the next cycle if the winner drops req, or via round-robin if it stays.
- While reset = 1:
  - c_gnt and d_gnt forced 0.
  - m_en = 0, m_we = 0000.
  - Outputs reset to: rvalid 0, err 0, rdata 0, `last` = D (so C wins first).
- Reset asserted between grant and response: the pending response is discarded and no rvalid is issued.

## Configuration
- DM_ARB_FIXED_PRIO_EN:
  - Defined → port C always wins on conflict; `last` is not implemented, so D can starve.
  - Undefined → round-robin as above.

## Test plan
- Round-robin conflict:
  - Stimulus: from reset, both ports request word loads (C addr 0x10, D addr 0x20) for 4 cycles.
  - Response: grants C, D, C, D; responses arrive one cycle later on the matching port.
- Half store then signed/unsigned loads:
  - Stimulus: C half store 0x8001 at addr 0x6. Then C half load addr 0x6 with signed = 1, then with signed = 0.
  - Response: m_we = 1100, m_wdata = 0x80018001; loads return 0xFFFF8001, then 0x00008001.
- Byte lanes:
  - Stimulus: D byte-stores 0xA5 to addresses 0x40..0x43, then word-loads 0x40.
  - Response: strobes 0001, 0010, 0100, 1000; load returns 0xA5A5A5A5.
- Misaligned access:
  - Stimulus: C word load at addr 0x13.
  - Response: gnt in T, m_en = 0; in T+1 c_err = 1, c_rvalid = 1, c_rdata = 0.
- Reset mid-access:
  - Stimulus: assert reset asynchronously after a C load grant, before the clock edge.
  - Response: gnt drops immediately, no rvalid follows, and C wins the first conflict after release.
- Fixed-priority build:
  - Stimulus: with DM_ARB_FIXED_PRIO_EN defined, both ports request continuously for 5 cycles.
  - Response: C granted all 5 cycles, d_gnt stays 0.
